// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Flushed or reset IF/ID slots carry NOP_INSTR so Decode never sees an all-zero opcode.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [31:0]           FetchCount
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] pc_sel;
  logic [DATA_WIDTH-1:0] pc_next;

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] pc_plus4d_q, pc_plus4d_d;
  logic                  valid_q, valid_d;
  logic [31:0]           count_q, count_d;
  logic                  load_d;

  // A redirect must land even while Fetch is stalled, otherwise the wrong path keeps running.
  always_comb begin
    pc_plus4_f = pc_q + DATA_WIDTH'(4);
    pc_sel     = PCSrcE ? PCTargetE : pc_plus4_f;
    pc_next    = {pc_sel[DATA_WIDTH-1:2], 2'b00};
    pc_d       = pc_q;
    if (PCSrcE || !StallF) begin
      pc_d = pc_next;
    end
  end

  always_comb begin
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    pc_plus4d_d = pc_plus4d_q;
    valid_d     = valid_q;
    count_d     = count_q;
    load_d      = !FlushD && !StallD;
    if (FlushD) begin
      instr_d     = NOP_INSTR;
      pcd_d       = '0;
      pc_plus4d_d = '0;
      valid_d     = 1'b0;
    end else if (load_d) begin
      instr_d     = InstrF;
      pcd_d       = pc_q;
      pc_plus4d_d = pc_plus4_f;
      valid_d     = 1'b1;
      count_d     = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      pc_plus4d_q <= '0;
      valid_q     <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pc_plus4d_q <= pc_plus4d_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pc_plus4d_q;
  assign ValidD     = valid_q;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a small instruction-memory model.
// Expected values in the table are worked out by hand from the memory map below.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD;

  int testsRun;
  int testsFailed;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchCount (FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: two real instructions at 0 and 4, everywhere else 0xA000_0000 | address.
  always_comb begin
    case (PCF)
      32'h0000_0000: InstrF = 32'h0050_0093;
      32'h0000_0004: InstrF = 32'h00A0_0113;
      default:       InstrF = 32'hA000_0000 | PCF;
    endcase
  end

  typedef struct {
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrcE;
    logic [31:0] target;
    logic [31:0] expPcf;
    logic [31:0] expInstr;
    logic [31:0] expPcd;
    logic [31:0] expPlus4;
    logic        expValid;
    logic [31:0] expCount;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] ePcf, input logic [31:0] eInstr,
                          input logic [31:0] ePcd, input logic [31:0] ePlus4,
                          input logic eValid, input logic [31:0] eCount);
    checkOutput({tag, " PCF"},        PCF,              ePcf);
    checkOutput({tag, " InstrD"},     InstrD,           eInstr);
    checkOutput({tag, " PCD"},        PCD,              ePcd);
    checkOutput({tag, " PCPlus4D"},   PCPlus4D,         ePlus4);
    checkOutput({tag, " ValidD"},     {31'd0, ValidD},  {31'd0, eValid});
    checkOutput({tag, " FetchCount"}, FetchCount,       eCount);
  endtask

  // Drive controls just after a negedge, clock one rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                               input logic src, input logic [31:0] tgt);
    StallF    = sF;
    StallD    = sD;
    FlushD    = fD;
    PCSrcE    = src;
    PCTargetE = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    //               sF sD fD src target         PCF            InstrD         PCD            PCPlus4D       V  Count
    vecs[0]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 1, 32'd1};
    vecs[1]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0008, 32'h00A0_0113, 32'h0000_0004, 32'h0000_0008, 1, 32'd2};
    vecs[2]  = '{0, 0, 0, 0, 32'h0, 32'h0000_000C, 32'hA000_0008, 32'h0000_0008, 32'h0000_000C, 1, 32'd3};
    vecs[3]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0010, 32'hA000_000C, 32'h0000_000C, 32'h0000_0010, 1, 32'd4};
    // load-use stall for two cycles at PCF = 0x10
    vecs[4]  = '{1, 1, 0, 0, 32'h0, 32'h0000_0010, 32'hA000_000C, 32'h0000_000C, 32'h0000_0010, 1, 32'd4};
    vecs[5]  = '{1, 1, 0, 0, 32'h0, 32'h0000_0010, 32'hA000_000C, 32'h0000_000C, 32'h0000_0010, 1, 32'd4};
    vecs[6]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0014, 32'hA000_0010, 32'h0000_0010, 32'h0000_0014, 1, 32'd5};
    vecs[7]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0018, 32'hA000_0014, 32'h0000_0014, 32'h0000_0018, 1, 32'd6};
    // branch redirect to 0x40 with flush
    vecs[8]  = '{0, 0, 1, 1, 32'h40, 32'h0000_0040, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0, 32'd6};
    vecs[9]  = '{0, 0, 0, 0, 32'h0, 32'h0000_0044, 32'hA000_0040, 32'h0000_0040, 32'h0000_0044, 1, 32'd7};
    // everything asserted: flush beats stall, redirect beats stall, low target bits masked
    vecs[10] = '{1, 1, 1, 1, 32'h83, 32'h0000_0080, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0, 32'd7};
    // StallF alone: same PC re-fetched and counted each cycle
    vecs[11] = '{1, 0, 0, 0, 32'h0, 32'h0000_0080, 32'hA000_0080, 32'h0000_0080, 32'h0000_0084, 1, 32'd8};
    vecs[12] = '{1, 0, 0, 0, 32'h0, 32'h0000_0080, 32'hA000_0080, 32'h0000_0080, 32'h0000_0084, 1, 32'd9};
    // redirect to the top word without flush, then wrap of PC and PCPlus4D
    vecs[13] = '{0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA000_0080, 32'h0000_0080, 32'h0000_0084, 1, 32'd10};
    vecs[14] = '{0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1, 32'd11};
    vecs[15] = '{0, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 1, 32'd12};
    // head to PCF = 0x24 with a real instruction in D, then stall there
    vecs[16] = '{0, 0, 1, 1, 32'h20, 32'h0000_0020, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0, 32'd12};
    vecs[17] = '{0, 0, 0, 0, 32'h0, 32'h0000_0024, 32'hA000_0020, 32'h0000_0020, 32'h0000_0024, 1, 32'd13};
    vecs[18] = '{1, 1, 0, 0, 32'h0, 32'h0000_0024, 32'hA000_0020, 32'h0000_0020, 32'h0000_0024, 1, 32'd13};

    // Reset: async assertion takes effect with no edge, and holds across an edge.
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    rst       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkAll("reset-async", 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    checkAll("reset-held", 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].stallF, vecs[i].stallD, vecs[i].flushD, vecs[i].pcSrcE, vecs[i].target);
      checkAll($sformatf("vec%0d", i), vecs[i].expPcf, vecs[i].expInstr, vecs[i].expPcd,
               vecs[i].expPlus4, vecs[i].expValid, vecs[i].expCount);
      @(negedge clk);
    end

    // Async reset in the middle of a stall at PCF = 0x24, checked before any edge.
    StallF = 1'b1;
    StallD = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkAll("midstall-reset", 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after release loads the word at RESET_PC.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("post-reset", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the pipelined RISC-V core. Holds the PC, selects the next PC (sequential or redirected by a resolved branch/jump from Execute), presents PCF to instruction memory, and registers the returned word into the Decode stage. It directly feeds the main decoder: InstrD[6:0] is the decoder's `op` input. Flushed slots carry a canonical NOP, never zero. This matters because an all-zero opcode decodes to the default case with Jump asserted.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- StallF  input  1  hold PC register
- StallD  input  1  hold IF/ID register
- FlushD  input  1  replace IF/ID contents with a bubble
- PCSrcE  input  1  taken branch/jump resolved in Execute
- PCTargetE  input  DATA_WIDTH  redirect target
- InstrF  input  DATA_WIDTH  instruction memory read data for PCF (combinational read)
- PCF  output  DATA_WIDTH  current fetch address
- InstrD  output  DATA_WIDTH  registered instruction to Decode
- PCD  output  DATA_WIDTH  PC of InstrD
- PCPlus4D  output  DATA_WIDTH  PCD + 4
- ValidD  output  1  InstrD is a real fetched instruction (0 for a bubble)
- FetchCount  output  32  number of real instructions loaded into IF/ID

## Operation
- PCPlus4F = PCF + 4, modulo 2^DATA_WIDTH. 0xFFFF_FFFC wraps to 0x0000_0000.
- PCNext = PCSrcE ? PCTargetE : PCPlus4F, with bits [1:0] forced to 2'b00.
- PC register update priority: rst, then PCSrcE (redirect wins over StallF), then StallF (hold), then load PCNext.
- IF/ID update priority:
  - rst: bubble.
  - FlushD: bubble. FlushD wins over StallD.
  - StallD: hold all D outputs.
  - Otherwise: load InstrF, PCF, PCPlus4F, and set ValidD = 1.
- Bubble: InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
- FetchCount increments by 1 on each edge where IF/ID loads (no rst, no FlushD, no StallD). It wraps 0xFFFF_FFFF to 0 and resets to 0.
- The block has no internal FSM. Its state is PC, the IF/ID register and FetchCount. Control (stall/flush generation) lives in the hazard unit.

## Timing
- Reset values while rst is high and after async assertion: PCF = RESET_PC, InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, FetchCount = 0. Assertion takes effect immediately, not at the next edge.
- Reset deassertion: the first rising edge after deassertion loads the IF/ID register with InstrF at RESET_PC, and PCF advances to RESET_PC + 4.
- Fetch-to-decode latency: 1 cycle. InstrD/PCD at cycle N+1 equal InstrF/PCF sampled at edge N.
- Redirect: if PCSrcE is high at edge N, PCF = PCTargetE after edge N. The hazard unit asserts FlushD in the same cycle, so the wrong-path instruction becomes a bubble.
- Stall: StallF and StallD both high holds PCF and all D outputs unchanged for every stalled cycle. FetchCount does not increment.
- StallF = 1 with StallD = 0 (not generated by the hazard unit) is legal. The same PCF is re-fetched into IF/ID each cycle, and each load counts.
- Reset mid-operation overrides any stall, flush or redirect in progress.

## Test plan
- Reset/sequential fetch: assert rst, release, memory returns 0x00500093 at 0 and 0x00A00113 at 4. PCF goes 0 → 4 → 8. InstrD = NOP_INSTR during reset, then 0x00500093 with PCD = 0, PCPlus4D = 4, ValidD = 1, then 0x00A00113. FetchCount = 2 after two loads.
- Load-use stall: StallF = StallD = 1 for 2 cycles at PCF = 0x10. PCF stays 0x10, D outputs unchanged, FetchCount frozen. Normal advance resumes on release.
- Branch redirect: PCSrcE = 1, PCTargetE = 0x40, FlushD = 1 at PCF = 0x18. Next cycle PCF = 0x40, InstrD = 0x00000013, ValidD = 0. The following cycle InstrD = word at 0x40 and PCD = 0x40.
- Priority: FlushD = StallD = 1 with PCSrcE = StallF = 1 and PCTargetE = 0x83. D becomes a bubble, and PCF = 0x80 (low bits masked).
- Wrap: force PCF to 0xFFFF_FFFC, no stall. Next PCF = 0, and PCPlus4D for that instruction = 0.
- Async reset mid-stall: StallF = StallD = 1, PCF = 0x24, assert rst between edges. All outputs return to reset values immediately, with no clock edge needed.
